// File: rtl/onehot_sequencer.sv
// Purpose : walks a 4-bit one-hot code up or down for a programmed number of steps.
// Latency : start sampled at edge N gives the seed code during cycle N+1; done follows the last accept by one cycle.
// Backpressure: code and code_valid hold while code_ready is low; one code per cycle when ready is held high.
//
// Ports:
//   clk, rst          - single clock, asynchronous active-high reset
//   start, dir, steps - launch request; dir (0 = up, 1 = down) and steps (0 = 16) are sampled with start in IDLE
//   code, code_valid  - one-hot code offered to the consumer; code is 0000 whenever code_valid is low
//   code_ready        - consumer accept; a handshake is code_valid & code_ready
//   busy              - high while a run is in EMIT or DONE
//   done              - one-cycle pulse after the last code is accepted
//   err               - only when ONEHOT_SEQ_SELFCHECK_EN is defined: sticky flag for a malformed code
module onehot_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir,
  input  logic [3:0] steps,
  output logic [3:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       busy,
  output logic       done
`ifdef ONEHOT_SEQ_SELFCHECK_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic       dir_q;
  logic [4:0] remaining;  // 5 bits so that steps = 0 can be held as 16

  // All outputs are flops written alongside the state, so nothing
  // combinational reaches code / code_valid from code_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      remaining  <= 5'd0;
      code       <= 4'b0000;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= EMIT;
            dir_q      <= dir;
            remaining  <= (steps == 4'd0) ? 5'd16 : {1'b0, steps};
            code       <= dir ? 4'b1000 : 4'b0001;
            code_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end

        EMIT: begin
          if (code_ready) begin
            if (remaining > 5'd1) begin
              remaining <= remaining - 5'd1;
              code      <= dir_q ? {code[0], code[3:1]} : {code[2:0], code[3]};
            end else begin
              // Last code accepted: blank the code so it never shows
              // outside a valid cycle, and raise done for one cycle.
              state      <= DONE;
              remaining  <= 5'd0;
              code       <= 4'b0000;
              code_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          remaining  <= 5'd0;
          code       <= 4'b0000;
          code_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

`ifdef ONEHOT_SEQ_SELFCHECK_EN
  // A power-of-two test: exactly one bit set iff nonzero and x & (x-1) == 0.
  logic code_onehot;
  logic code_bad;

  always_comb begin
    code_onehot = (code != 4'b0000) && ((code & (code - 4'd1)) == 4'b0000);
    code_bad    = code_valid ? !code_onehot : (code != 4'b0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (code_bad) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_onehot_sequencer.sv
// Purpose : self-checking bench for onehot_sequencer (directed scenarios plus randomized traffic).
// Latency : outputs are compared each falling edge against a run-level model updated on rising edges.
// Backpressure: code_ready is driven with directed stalls and random low cycles.
module tb_onehot_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dir;
  logic [3:0] steps;
  logic [3:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       busy;
  logic       done;
`ifdef ONEHOT_SEQ_SELFCHECK_EN
  logic       err;
`endif

  onehot_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dir        (dir),
    .steps      (steps),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .busy       (busy),
    .done       (done)
`ifdef ONEHOT_SEQ_SELFCHECK_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
  endtask

  // Run-level reference: a run is "emit k codes, index i", code i is
  // the seed shifted i mod 4 places; then one done cycle.
  bit m_active = 0;
  bit m_done   = 0;
  bit m_dir    = 0;
  int m_idx    = 0;
  int m_k      = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_done   = 0;
      m_idx    = 0;
      m_k      = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (code_ready) begin
        m_idx++;
        if (m_idx == m_k) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (start) begin
      m_active = 1;
      m_idx    = 0;
      m_k      = (steps == 4'd0) ? 16 : int'(steps);
      m_dir    = dir;
    end
  end

  function automatic logic [3:0] model_code();
    logic [3:0] up_seed;
    logic [3:0] dn_seed;
    up_seed = 4'b0001;
    dn_seed = 4'b1000;
    if (!m_active) return 4'b0000;
    return m_dir ? (dn_seed >> (m_idx % 4)) : (up_seed << (m_idx % 4));
  endfunction

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("code",       32'(code),       32'(model_code()));
      check("code_valid", 32'(code_valid), 32'(m_active));
      check("busy",       32'(busy),       32'(m_active | m_done));
      check("done",       32'(done),       32'(m_done));
`ifdef ONEHOT_SEQ_SELFCHECK_EN
      check("err",        32'(err),        32'(0));
`endif
    end
  end

  task automatic drive(input logic s, input logic d, input logic [3:0] st, input logic r);
    start      = s;
    dir        = d;
    steps      = st;
    code_ready = r;
  endtask

  int vld_cnt;
  int busy_cnt;
  int done_cnt;

  initial begin
    logic [3:0] seq_up3 [3];
    logic [3:0] seq_dn6 [6];
    seq_up3 = '{4'b0001, 4'b0010, 4'b0100};
    seq_dn6 = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};

    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    check("rst_code",  32'(code),       32'(0));
    check("rst_valid", 32'(code_valid), 32'(0));
    check("rst_busy",  32'(busy),       32'(0));
    check("rst_done",  32'(done),       32'(0));
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1;

    // Up, 3 steps, ready high.
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("up3_code",  32'(code),       32'(seq_up3[i]));
      check("up3_valid", 32'(code_valid), 32'(1));
    end
    @(negedge clk);
    check("up3_done",       32'(done),       32'(1));
    check("up3_done_valid", 32'(code_valid), 32'(0));
    @(negedge clk);
    check("up3_idle_done", 32'(done), 32'(0));
    check("up3_idle_code", 32'(code), 32'(0));
    check("up3_idle_busy", 32'(busy), 32'(0));

    // Down, 6 steps: wraps past 0001 back to 1000.
    drive(1'b1, 1'b1, 4'd6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("dn6_code", 32'(code), 32'(seq_dn6[i]));
    end
    @(negedge clk);
    check("dn6_done", 32'(done), 32'(1));
    @(negedge clk);

    // steps = 0 means 16 codes, busy for 17 cycles.
    drive(1'b1, 1'b0, 4'd0, 1'b1);
    vld_cnt  = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (code_valid) vld_cnt++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check("s16_valid_cycles", 32'(vld_cnt),  32'(16));
    check("s16_busy_cycles",  32'(busy_cnt), 32'(17));
    check("s16_done_pulses",  32'(done_cnt), 32'(1));

    // Stall: ready low for 3 cycles after launch, start pulses ignored.
    drive(1'b1, 1'b0, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 4'd5, 1'b0);
      check("stall_code",  32'(code),       32'(4'b0001));
      check("stall_valid", 32'(code_valid), 32'(1));
    end
    drive(1'b1, 1'b1, 4'd5, 1'b1);
    @(negedge clk);
    check("stall_adv_code", 32'(code), 32'(4'b0010));
    @(negedge clk);
    start = 1'b0;
    check("stall_done", 32'(done), 32'(1));
    @(negedge clk);
    check("stall_idle_busy", 32'(busy), 32'(0));

    // Asynchronous reset between edges in the middle of a run.
    drive(1'b1, 1'b0, 4'd8, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_code",  32'(code),       32'(0));
    check("arst_valid", 32'(code_valid), 32'(0));
    check("arst_busy",  32'(busy),       32'(0));
    check("arst_done",  32'(done),       32'(0));
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_start_ignored", 32'(code_valid), 32'(0));
    rst = 1'b0;
    drive(1'b1, 1'b1, 4'd2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("arst_restart_seed", 32'(code), 32'(4'b1000));
    repeat (3) @(negedge clk);

    // Randomized traffic with occasional reset glitches.
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      @(negedge clk);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/onehot_sequencer.md
# onehot_sequencer

Generates a sequence of 4-bit one-hot codes under a valid/ready handshake. It is the producing end of the one-hot status path: downstream one-hot detection logic consumes each code and accepts it. A start pulse launches a walk of a programmable number of codes in either direction, wrapping around the 4-bit vector. Completion is reported with a `done` pulse.

## Interface
- No parameters. Code width is fixed at 4 bits; the step counter is fixed at 4 bits.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset. Clears all state immediately, independent of `clk`.
- `start` input 1: launch request. Sampled only in IDLE.
- `dir` input 1: walk direction, sampled with `start`.
  - 0 = up: 0001→0010→0100→1000→0001…
  - 1 = down: 1000→0100→0010→0001→1000…
- `steps` input 4: number of codes to emit, sampled with `start`. Value 0 means 16.
- `code` output 4: current one-hot code. Forced to 0000 whenever `code_valid`=0.
- `code_valid` output 1: `code` is presented.
- `code_ready` input 1: consumer accepts `code` on a cycle where `code_valid`=1 and `code_ready`=1.
- `busy` output 1: high in EMIT and DONE.
- `done` output 1: one-cycle pulse after the last code is accepted.

## Operation
- State machine with three states: IDLE, EMIT, DONE. Reset state is IDLE.
- IDLE:
  - `code_valid`=0, `code`=0000, `busy`=0, `done`=0.
  - When `start`=1 at a clock edge: latch `dir`, load `remaining` = `steps` (0 loads 16; `remaining` is a 5-bit internal counter), load the seed (0001 if up, 1000 if down), go to EMIT.
- EMIT:
  - `code_valid`=1, `busy`=1, `code` = current register.
  - On a handshake with `remaining`>1: rotate the code register by one position in the latched direction and decrement `remaining`.
  - On a handshake with `remaining`=1: go to DONE.
  - Without a handshake: `code` and `remaining` hold, and `code_valid` stays high. The producer never withdraws `code_valid` without a handshake.
- DONE:
  - `code_valid`=0, `code`=0000, `done`=1, `busy`=1.
  - Unconditionally returns to IDLE on the next edge.
- Rotation:
  - Up: code <= {code[2:0], code[3]}.
  - Down: code <= {code[0], code[3:1]}.
  - Wrap-around is continuous, so runs longer than 4 steps revisit the codes.
- Input handling:
  - `start` is ignored in EMIT and DONE. It is not queued.
  - `dir` and `steps` changes after launch have no effect.
- The code register only ever holds one-hot values or 0000.

## Timing
- Start latency: `start` high at edge N puts `code_valid`=1 with the seed code during cycle N+1.
- Throughput: one code per cycle while `code_ready` is held high. A k-step run with ready always high has `code_valid` high for exactly k cycles.
- Completion: a handshake on the last code at edge M gives `done`=1 during cycle M+1 and IDLE from edge M+2. The earliest relaunch is a `start` sampled at edge M+2.
- Outputs are registered-state decodes with no combinational path from `code_ready` to `code`. `code_valid` does not depend combinationally on `code_ready`.
- Reset mid-run: `rst` asserted in any state forces the following immediately and asynchronously:
  - `code`=0000, `code_valid`=0, `busy`=0, `done`=0, `remaining`=0, state IDLE.
  - An in-flight run is abandoned, and no `done` pulse is produced.
- While `rst` is high, `start` is ignored.

## Configuration
- Macro `ONEHOT_SEQ_SELFCHECK_EN`.
- When defined: adds output `err` (1 bit, reset 0) and an internal one-hot detector on the code register.
  - `err` goes high and sticks until `rst` if any cycle has `code_valid`=1 with a code that is not exactly one-hot, or `code_valid`=0 with a code other than 0000.
- When undefined: no `err` port and no detector logic. Functional behaviour is otherwise identical.

## Test plan
- Reset, then `start`=1 with `dir`=0, `steps`=3, and `code_ready` held high → codes 0001, 0010, 0100 on three consecutive cycles, then `done`=1 for one cycle, then IDLE with `code`=0000.
- `dir`=1, `steps`=6, ready high → 1000, 0100, 0010, 0001, 1000, 0100, then `done`; the sequence confirms wrap-around.
- `steps`=0, ready high → exactly 16 codes emitted, with `busy` high for 17 cycles.
- `dir`=0, `steps`=2, with `code_ready` low for 3 cycles after launch → 0001 held with `code_valid`=1 throughout the stall; advances to 0010 only after ready rises; `start` pulses during the run are ignored.
- Assert `rst` asynchronously mid-EMIT, between clock edges → `code`=0000 and `code_valid`=0 before the next edge; no `done`; after release, a fresh `start` restarts from the seed.
- With `ONEHOT_SEQ_SELFCHECK_EN` defined, run all of the above → `err` remains 0.
